// File: rtl/tx_fire_sequencer_pkg.sv
// Shared definitions for the transmit fire sequencer and the per-channel output stages.
package tx_fire_sequencer_pkg;

    localparam int CNTR_W = 32;

    // Channel command encodings; the channel stage decodes the same values.
    localparam logic [1:0] CMD_WAIT  = 2'b00;
    localparam logic [1:0] CMD_FIRE  = 2'b01;
    localparam logic [1:0] CMD_RESET = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        CLEAR  = 3'd4,
        GAP    = 3'd5
    } state_e;

    function automatic logic [1:0] state_cmd(input state_e s);
        logic [1:0] c;
        c = CMD_WAIT;
        if (s == ARM || s == RUN) c = CMD_FIRE;
        else if (s == CLEAR)      c = CMD_RESET;
        return c;
    endfunction

endpackage

// File: rtl/tx_fire_sequencer_timebase.sv
// Shared timebase: clear/enable counter that saturates at all-ones, with an equality compare.
module tx_timebase_counter
    import tx_fire_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [CNTR_W-1:0] cmp_i,
    output logic [CNTR_W-1:0] cnt_o,
    output logic              eq_o
);

    logic [CNTR_W-1:0] cnt_q;
    logic [CNTR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign eq_o  = (cnt_q == cmp_i);

endmodule

// File: rtl/tx_fire_sequencer.sv
// Fire sequencer: arms channels, runs the shared timebase until all go idle or time out.
// Optional repetition bursts are enabled with `define TX_BURST_EN.
module tx_fire_sequencer
    import tx_fire_sequencer_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int ARM_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic              clearErr,
    input  logic [CNTR_W-1:0] timeoutCount,
    input  logic [NCH-1:0]    isActiveVec,
    input  logic [NCH-1:0]    errorFlagVec,
`ifdef TX_BURST_EN
    input  logic [7:0]        burstCount,
    input  logic [15:0]       burstGap,
    output logic [7:0]        burstIdx,
`endif
    output logic [CNTR_W-1:0] cntr,
    output logic [1:0]        cmd,
    output logic              busy,
    output logic              done,
    output logic              timeoutErr,
    output logic [NCH-1:0]    chanErr
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    state_e            state_q;
    state_e            state_d;
    logic [ARM_W-1:0]  arm_cnt_q;
    logic [ARM_W-1:0]  arm_cnt_d;
    logic              tmo_set;
    logic              tmo_hit;
    logic              cnt_eq;
    logic              fin_last;
    logic              timeout_err_q;
    logic [NCH-1:0]    chan_err_q;
    logic [CNTR_W-1:0] cnt_val;

`ifdef TX_BURST_EN
    logic [15:0]       gap_cnt_q;
    logic [15:0]       gap_cnt_d;
    logic [7:0]        burst_idx_q;
    logic              abort_q;

    // A timeout ends the whole burst, not just the current repetition.
    assign fin_last = abort_q || (burst_idx_q == burstCount);
`else
    assign fin_last = 1'b1;
`endif

    assign tmo_hit = (timeoutCount != '0) && cnt_eq;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = '0;
        tmo_set   = 1'b0;
`ifdef TX_BURST_EN
        gap_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (clearErr) begin
                    state_d = CLEAR;
                end else if (trigger) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                arm_cnt_d = arm_cnt_q + ARM_W'(1);
                if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (isActiveVec == '0) begin
                    state_d = FINISH;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
`ifdef TX_BURST_EN
                if (fin_last) begin
                    state_d = IDLE;
                end else if (burstGap == 16'd0) begin
                    state_d = ARM;
                end else begin
                    state_d = GAP;
                end
`else
                state_d = IDLE;
`endif
            end
            CLEAR: begin
                state_d = IDLE;
            end
`ifdef TX_BURST_EN
            GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_cnt_q == (burstGap - 16'd1)) begin
                    state_d = ARM;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

`ifdef TX_BURST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt_q   <= '0;
            burst_idx_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
            if (state_q == IDLE) begin
                burst_idx_q <= '0;
                abort_q     <= 1'b0;
            end else begin
                if (state_q == FINISH && state_d != IDLE) begin
                    burst_idx_q <= burst_idx_q + 8'd1;
                end
                if (tmo_set) begin
                    abort_q <= 1'b1;
                end
            end
        end
    end

    assign burstIdx = burst_idx_q;
`endif

    // Counter is zero everywhere outside RUN, including the FINISH cycle.
    tx_timebase_counter u_timebase (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_d != RUN),
        .en_i  (state_q == RUN),
        .cmp_i (timeoutCount),
        .cnt_o (cnt_val),
        .eq_o  (cnt_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            timeout_err_q <= 1'b0;
        end else if (tmo_set) begin
            timeout_err_q <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan_err
        always_ff @(posedge clk) begin
            if (reset) begin
                chan_err_q[gi] <= 1'b0;
            end else if (state_q == CLEAR) begin
                chan_err_q[gi] <= 1'b0;
            end else if ((state_q != IDLE) && errorFlagVec[gi]) begin
                chan_err_q[gi] <= 1'b1;
            end
        end
    end

    assign cntr       = cnt_val;
    assign cmd        = state_cmd(state_q);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH) && fin_last;
    assign timeoutErr = timeout_err_q;
    assign chanErr    = chan_err_q;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Scoreboard bench for tx_fire_sequencer; burst scenario runs when TX_BURST_EN is defined.
`timescale 1ns/1ps
module tb_tx_fire_sequencer;
    import tx_fire_sequencer_pkg::*;

    localparam int NCH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           trigger;
    logic           clearErr;
    logic [31:0]    timeoutCount;
    logic [NCH-1:0] isActiveVec;
    logic [NCH-1:0] errorFlagVec;
    logic [31:0]    cntr;
    logic [1:0]     cmd;
    logic           busy;
    logic           done;
    logic           timeoutErr;
    logic [NCH-1:0] chanErr;
`ifdef TX_BURST_EN
    logic [7:0]     burstCount;
    logic [15:0]    burstGap;
    logic [7:0]     burstIdx;
`endif

    tx_fire_sequencer #(.NCH(NCH), .ARM_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .trigger      (trigger),
        .clearErr     (clearErr),
        .timeoutCount (timeoutCount),
        .isActiveVec  (isActiveVec),
        .errorFlagVec (errorFlagVec),
`ifdef TX_BURST_EN
        .burstCount   (burstCount),
        .burstGap     (burstGap),
        .burstIdx     (burstIdx),
`endif
        .cntr         (cntr),
        .cmd          (cmd),
        .busy         (busy),
        .done         (done),
        .timeoutErr   (timeoutErr),
        .chanErr      (chanErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             lat;
        int             fires;
        int             maxc;
        logic           tmo;
        logic [NCH-1:0] cerr;
        logic [7:0]     idx;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   trig_cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   act_mode = 0;
    int   act_lim = 0;
    bit   err_en = 1'b0;
    int   mon_fires = 0;
    int   mon_maxc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Channel model: all channels active until cntr reaches act_lim, or channel 0 stuck active.
    always_comb begin
        isActiveVec  = '0;
        errorFlagVec = '0;
        if (act_mode == 1 && cntr < 32'(act_lim)) isActiveVec = '1;
        else if (act_mode == 2)                  isActiveVec = 8'h01;
        if (err_en && cntr == 32'd3 && cmd == CMD_FIRE) errorFlagVec = 8'h04;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fire(input int lat, input int fires, input int maxc, input logic tmo,
                        input logic [NCH-1:0] cerr, input logic [7:0] idx);
        exp_t e;
        e = '{lat, fires, maxc, tmo, cerr, idx};
        sb.push_back(e);
        trig_cyc = cyc;
        trigger  = 1'b1;
        step(1);
        trigger  = 1'b0;
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_fires = 0;
                mon_maxc  = 0;
            end else begin
                if (cmd == CMD_FIRE) mon_fires++;
                if (int'(cntr) > mon_maxc) mon_maxc = int'(cntr);
                if (done) begin
                    chk("done_expected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("latency", 32'(cyc - trig_cyc), 32'(e.lat));
                        chk("fire_cycles", 32'(mon_fires), 32'(e.fires));
                        chk("max_cntr", 32'(mon_maxc), 32'(e.maxc));
                        chk("done_timeoutErr", 32'(timeoutErr), 32'(e.tmo));
                        chk("done_chanErr", 32'(chanErr), 32'(e.cerr));
                        chk("done_cmd", 32'(cmd), 32'(CMD_WAIT));
                        chk("done_cntr", cntr, 32'd0);
`ifdef TX_BURST_EN
                        chk("done_burstIdx", 32'(burstIdx), 32'(e.idx));
`endif
                        $display("txn done: lat=%0d fires=%0d maxc=%0d tmo=%0b chanErr=%02h",
                                 cyc - trig_cyc, mon_fires, mon_maxc, timeoutErr, chanErr);
                    end
                    mon_fires = 0;
                    mon_maxc  = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        reset        = 1'b1;
        trigger      = 1'b0;
        clearErr     = 1'b0;
        timeoutCount = 32'd0;
`ifdef TX_BURST_EN
        burstCount   = 8'd0;
        burstGap     = 16'd0;
`endif
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd", 32'(cmd), 32'(CMD_WAIT));
        chk("rst_cntr", cntr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeoutErr", 32'(timeoutErr), 32'd0);
        chk("rst_chanErr", 32'(chanErr), 32'd0);
        step(1);

        // Normal run to cntr=50, with a stray trigger while busy.
        act_mode = 1; act_lim = 50;
        fire(54, 53, 50, 1'b0, 8'h00, 8'd0);
        step(10);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        wait_drain(200, "run50");
        @(negedge clk);
        chk("run50_idle_cmd", 32'(cmd), 32'(CMD_WAIT));
        chk("run50_idle_busy", 32'(busy), 32'd0);
        step(2);

        // All channels idle from the start: minimum sequence.
        act_mode = 0;
        fire(4, 3, 0, 1'b0, 8'h00, 8'd0);
        wait_drain(20, "zero");
        step(2);

        // Stuck channel with timeout.
        act_mode = 2; timeoutCount = 32'd1000;
        fire(1004, 1003, 1000, 1'b1, 8'h00, 8'd0);
        wait_drain(1100, "timeout");
        @(negedge clk);
        chk("timeout_sticky", 32'(timeoutErr), 32'd1);
        step(2);

        // Channel error during RUN, then clear.
        act_mode = 1; act_lim = 5; err_en = 1'b1; timeoutCount = 32'd0;
        fire(9, 8, 5, 1'b1, 8'h04, 8'd0);
        wait_drain(30, "chanerr");
        err_en = 1'b0;
        step(2);
        @(negedge clk);
        chk("chanErr_held", 32'(chanErr), 32'h04);
        step(1);
        clearErr = 1'b1;
        step(1);
        clearErr = 1'b0;
        @(negedge clk);
        chk("clear_cmd", 32'(cmd), 32'(CMD_RESET));
        chk("clear_busy", 32'(busy), 32'd1);
        step(1);
        @(negedge clk);
        chk("clear_after_cmd", 32'(cmd), 32'(CMD_WAIT));
        chk("clear_chanErr", 32'(chanErr), 32'd0);
        chk("clear_timeoutErr", 32'(timeoutErr), 32'd0);
        step(1);

        // clearErr beats a simultaneous trigger; the trigger is dropped.
        clearErr = 1'b1; trigger = 1'b1;
        step(1);
        clearErr = 1'b0; trigger = 1'b0;
        @(negedge clk);
        chk("prio_cmd", 32'(cmd), 32'(CMD_RESET));
        step(1);
        @(negedge clk);
        chk("prio_busy", 32'(busy), 32'd0);
        step(3);
        @(negedge clk);
        chk("prio_no_arm", 32'(cmd), 32'(CMD_WAIT));
        step(1);

        // Reset in the middle of RUN.
        act_mode = 1; act_lim = 50;
        fire(0, 0, 0, 1'b0, 8'h00, 8'd0);
        n = 0;
        while (cntr != 32'd20 && n < 100) begin
            step(1);
            n++;
        end
        chk("midrst_reach20", cntr, 32'd20);
        reset = 1'b1;
        sb.delete();
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_cmd", 32'(cmd), 32'(CMD_WAIT));
        chk("midrst_cntr", cntr, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        step(60);
        act_lim = 10;
        fire(14, 13, 10, 1'b0, 8'h00, 8'd0);
        wait_drain(40, "retrig");
        step(2);

`ifdef TX_BURST_EN
        // Three repetitions, 10-cycle gaps.
        burstCount = 8'd2; burstGap = 16'd10; act_lim = 5;
        fire(47, 24, 5, 1'b0, 8'h00, 8'd2);
        wait_drain(100, "burst");
        step(1);
        @(negedge clk);
        chk("burst_idx_idle", 32'(burstIdx), 32'd0);
        burstCount = 8'd0; burstGap = 16'd0;
        step(2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_fire_sequencer.md
Name: tx_fire_sequencer

Overview:
- Upstream controller for the bank of per-channel transducer output stages.
- Drives the shared fire command and the shared 32-bit timebase counter into every channel.
- Waits for all channels to finish their charge windows, then returns them to idle.
- Aggregates per-channel isActive/errorFlag and reports done, timeout and error status to the host/register block.

Parameters:
- NCH, 8, number of transducer channels served.
- ARM_CYCLES, 2, cycles cmd=fire is held with cntr=0 before counting starts (channel latch + isActive settle).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  start-of-fire request; sampled in IDLE only.
- clearErr  input  1  one-cycle request to issue reset_module to channels and clear sticky flags.
- timeoutCount  input  32  cntr value at which RUN aborts; 0 means no timeout.
- isActiveVec  input  NCH  per-channel isActive.
- errorFlagVec  input  NCH  per-channel errorFlag (safety-valve trip).
- cntr  output  32  shared timebase to channels.
- cmd  output  2  shared channel command: 00 wait, 01 fire, 10 reset_module.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of a fire sequence.
- timeoutErr  output  1  sticky; set on timeout abort.
- chanErr  output  NCH  sticky OR of errorFlagVec captured while busy.

Behaviour:
- Reset values: cntr=0, cmd=00, busy=0, done=0, timeoutErr=0, chanErr=0, state=IDLE.
- Reset mid-sequence forces cmd=00 on the next edge, so channel outputs drop within one cycle.

States:
- IDLE: cmd=00, cntr=0.
  - clearErr -> CLEAR.
  - Else trigger -> ARM.
  - clearErr takes priority over a simultaneous trigger; the trigger is dropped.
- ARM: cmd=01, cntr held at 0 for ARM_CYCLES cycles (internal counter), then -> RUN.
- RUN: cmd=01; cntr increments by 1 each cycle, starting from 0 on the first RUN cycle.
  - If isActiveVec==0 -> FINISH. This includes the first RUN cycle, e.g. when all chargeTimes are 0.
  - Else if timeoutCount!=0 and cntr==timeoutCount -> set timeoutErr, -> FINISH.
  - cntr saturates at 32'hFFFF_FFFF and never wraps.
- FINISH: cmd=00 for one cycle, cntr=0, done=1 for this cycle -> IDLE.
- CLEAR: cmd=10 for one cycle; timeoutErr and chanErr cleared -> IDLE.

Timing and edge rules:
- trigger asserted while busy is ignored; no queuing.
- clearErr while busy is ignored.
- chanErr[i] is set whenever busy and errorFlagVec[i]=1. It is cleared only by CLEAR or reset.
- Latency: trigger cycle N -> cmd=01 at N+1 -> cntr=1 at N+1+ARM_CYCLES+1.
- The minimum sequence is 1+ARM_CYCLES+1+1 cycles from trigger to done.

Optional Feature:
- Macro: TX_BURST_EN.
- With it: adds input burstCount[7:0] (repetitions minus 1) and input burstGap[15:0].
  - Instead of IDLE, FINISH enters GAP while repetitions remain.
  - GAP holds cmd=00 for burstGap cycles (0 allowed), then -> ARM.
  - done pulses only after the final repetition.
  - A timeout aborts the remaining repetitions.
  - Adds output burstIdx[7:0], the current repetition index, which resets to 0 in IDLE.
- Without it: single fire per trigger; no GAP state, no extra ports.

Decomposition:
- Shared package holds:
  - cmd encodings CMD_WAIT=2'b00, CMD_FIRE=2'b01, CMD_RESET=2'b10, shared with the channel stage.
  - State enum IDLE/ARM/RUN/FINISH/CLEAR/GAP.
  - CNTR_W=32.
- One natural sub-module: tx_timebase_counter (clear/enable/saturating 32-bit counter with compare-equal output).

Test Plan:
- Trigger, 8 channels with isActive high until cntr=50, timeoutCount=0 -> cmd=01 for 2+51 cycles, done pulse one cycle after isActive drops, cmd returns to 00, timeoutErr=0.
- Trigger with isActiveVec stuck 8'h01, timeoutCount=1000 -> FINISH when cntr==1000, timeoutErr=1, done pulses, cmd=00.
- errorFlagVec=8'h04 during RUN, then clearErr in IDLE -> chanErr=8'h04 held after done; one cycle of cmd=10; chanErr=0 and timeoutErr=0 afterwards.
- isActiveVec=0 throughout (all chargeTimes zero) -> done exactly 4 cycles after trigger (ARM_CYCLES=2); cntr never exceeds 0.
- reset asserted at cntr=20 in RUN -> next edge cmd=00, cntr=0, busy=0, no done pulse; re-trigger works normally.
- TX_BURST_EN, burstCount=2, burstGap=10 -> three fire windows separated by 11 cycles of cmd=00 (1 FINISH + 10 GAP), burstIdx steps 0,1,2, a single done after the third.
